bean_scheduler: RTL and testbench
=================================

Name: bean_scheduler

Overview:
- Sequencer for the three-slot bean obstacle set consumed by the bean renderer.
- Owns slot positions, types and active flags, and scrolls them on each scroll tick.
- Spawns new beans at pseudo-random off-screen positions while enforcing a minimum gap between beans.
- Freezes all motion on a goose–bean hit, and clears everything on restart; downstream renderer draws from its registered outputs.

Parameters:
SHIFT, 5, pixels subtracted per tick from each active bean
MIN_GAP, 200, minimum (SCREEN_W-1) - furthest before a spawn is allowed
SCREEN_W, 640, visible width in pixels
SPAWN_BASE, 640, lowest spawn x; spawn x = SPAWN_BASE + lfsr[6:0] (640..767)
LFSR_SEED, 16'hACE1, LFSR reset value, must be nonzero

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
tick  in  1  scroll enable, one clk wide per scroll step
start  in  1  leave IDLE and begin running
hit  in  1  collision flag from renderer/collision logic
restart  in  1  synchronous clear back to IDLE
bean_x  out  30  slot i position at [10i+9:10i]
bean_type  out  3  per slot: 0 floor bean, 1 flying bean
bean_active  out  3  per slot valid
frozen  out  1  high in HIT state
dodged_count  out  16  beans scrolled off-screen since restart, saturating

Behaviour:
- Reset (async, reset_n=0):
  - State is IDLE; all bean_x=0, bean_type=0, bean_active=0.
  - frozen=0, dodged_count=0, lfsr=LFSR_SEED.
  - Outputs clear immediately, without waiting for a clock edge.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11, shift left, feedback into bit 0.
  - Advances every clk cycle in every state except during reset.
- FSM states IDLE, RUN, HIT. Priority per cycle: restart > hit > start/tick.
  - IDLE: start=1 -> RUN. tick ignored.
  - RUN: hit=1 -> HIT; that cycle's tick is discarded (no shift, no spawn). Otherwise tick=1 triggers a scroll step.
  - HIT: frozen=1; slots hold; tick/start ignored.
  - restart=1 in any state -> IDLE. Clears slots, flags and dodged_count; lfsr is not reseeded.
- Scroll step (one cycle, results registered, visible the cycle after tick):
  1. Each active slot: if x > SHIFT then x = x - SHIFT. Else x = 0, active = 0, and dodged_count += 1 (saturate at 16'hFFFF).
  2. Compute furthest = max post-shift x of still-active slots. If none are active, the gap is satisfied.
  3. Gap check: gap = (SCREEN_W-1) - furthest, computed 11-bit signed. Spawn only if gap >= MIN_GAP; a negative gap means no spawn.
  4. On spawn, the lowest-index inactive slot gets x = SPAWN_BASE + lfsr[6:0], type = lfsr[7], active = 1.
     - The spawned bean is not shifted on its spawn step.
     - At most one spawn per step.
     - No spawn if all 3 slots are active.
  5. Multiple slots expiring in one step each add 1 to dodged_count.
- Inactive slots never decrement and always read x=0.
- All outputs are registers; no combinational path from inputs to outputs.

Decomposition:
- Shared package bean_pkg holds:
  - N_BEANS=3
  - BEAN_FLOOR=0, BEAN_FLYING=1
  - the state enum {IDLE, RUN, HIT}
  - X_W=10
  - the LFSR tap constants
- Sub-module bean_lfsr16 (clk, reset_n, seed param, 16-bit state out) is natural and is shared with any future randomized spawner.
- Slot update and spawn select stay in bean_scheduler.

Test Plan:
- Async reset mid-RUN with slot0 at x=700: drop reset_n between clock edges -> bean_active=0, bean_x=0, frozen=0 before the next rising edge; state IDLE.
- start then a single tick with all slots empty: slot0 active at 640+lfsr[6:0] (checked against a bench LFSR model from 16'hACE1), type=lfsr[7]; slots 1–2 inactive.
- Preload slot0=700 via scrolling, then tick: slot0=695 next cycle. Slot at x=6 -> 1. Slot at x=5 -> inactive, x=0, dodged_count increments by 1.
- Gap boundary: only slot active, post-shift x=440 (gap 199) -> no spawn. Next case, post-shift x=439 (gap 200) -> slot1 spawns. With 3 slots active -> no spawn.
- hit and tick in the same cycle with slot0=500: slot0 stays 500, frozen=1. Further ticks leave 500. restart -> IDLE, all slots cleared, dodged_count=0, frozen=0.
- dodged_count at 16'hFFFF plus another expiry -> stays 16'hFFFF. restart and hit asserted together -> IDLE (restart wins).

Source files
------------

// File: rtl/bean_pkg.sv
// Shared types and constants for the bean obstacle sequencer.
package bean_pkg;

  localparam int N_BEANS = 3;
  localparam int X_W     = 10;

  localparam logic BEAN_FLOOR  = 1'b0;
  localparam logic BEAN_FLYING = 1'b1;

  // Fibonacci taps 16,14,13,11 expressed as state bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HIT
  } state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/bean_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; advances every cycle out of reset.
module bean_lfsr16
  import bean_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [15:0] state
);

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= SEED;
    else          state <= lfsr_next(state);
  end

endmodule

// File: rtl/bean_scheduler.sv
// Three-slot bean sequencer: scrolls slots on tick, spawns with a minimum gap,
// freezes on hit and clears on restart. All outputs are registers.
module bean_scheduler
  import bean_pkg::*;
#(
  parameter int          SHIFT      = 5,
  parameter int          MIN_GAP    = 200,
  parameter int          SCREEN_W   = 640,
  parameter int          SPAWN_BASE = 640,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     tick,
  input  logic                     start,
  input  logic                     hit,
  input  logic                     restart,
  output logic [N_BEANS*X_W-1:0]   bean_x,
  output logic [N_BEANS-1:0]       bean_type,
  output logic [N_BEANS-1:0]       bean_active,
  output logic                     frozen,
  output logic [15:0]              dodged_count
);

  typedef logic [X_W-1:0] x_t;

  localparam x_t                 SHIFT_X    = x_t'(SHIFT);
  localparam x_t                 SPAWN_X    = x_t'(SPAWN_BASE);
  localparam logic signed [10:0] RIGHT_EDGE = 11'(SCREEN_W - 1);
  localparam logic signed [10:0] GAP_LIMIT  = 11'(MIN_GAP);

  state_t                  state, state_n;
  logic [15:0]             lfsr;
  x_t   [N_BEANS-1:0]      x_q, x_n;
  logic [N_BEANS-1:0]      type_n, active_n;
  logic [15:0]             dodged_n;
  logic                    step;
  logic                    unused_lfsr_bits;

  bean_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .state   (lfsr)
  );

  // Only the low byte feeds spawn position and type.
  assign unused_lfsr_bits = ^lfsr[15:8];

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (hit)   state_n = HIT;
      HIT:     state_n = HIT;
      default: state_n = IDLE;
    endcase
    if (restart) state_n = IDLE;
  end

  // A hit in the same cycle as a tick discards the tick.
  assign step = (state == RUN) && tick && !hit && !restart;

  always_comb begin
    logic [1:0]         expired;
    x_t                 furthest;
    logic signed [10:0] gap;
    logic               spawn_ok;
    logic               spawned;
    logic [16:0]        sum;

    x_n      = x_q;
    type_n   = bean_type;
    active_n = bean_active;
    dodged_n = dodged_count;
    expired  = '0;
    furthest = '0;
    gap      = '0;
    spawn_ok = 1'b0;
    spawned  = 1'b0;
    sum      = '0;

    if (restart) begin
      x_n      = '0;
      type_n   = {N_BEANS{BEAN_FLOOR}};
      active_n = '0;
      dodged_n = '0;
    end else if (step) begin
      for (int i = 0; i < N_BEANS; i++) begin
        if (bean_active[i]) begin
          if (x_q[i] > SHIFT_X) begin
            x_n[i] = x_q[i] - SHIFT_X;
          end else begin
            x_n[i]      = '0;
            active_n[i] = 1'b0;
            expired     = expired + 2'd1;
          end
        end
      end

      for (int i = 0; i < N_BEANS; i++)
        if (active_n[i] && (x_n[i] > furthest)) furthest = x_n[i];

      // Signed so a bean still beyond the right edge yields a negative gap.
      gap      = RIGHT_EDGE - $signed({1'b0, furthest});
      spawn_ok = (active_n == '0) || (gap >= GAP_LIMIT);

      for (int i = 0; i < N_BEANS; i++) begin
        if (spawn_ok && !spawned && !active_n[i]) begin
          x_n[i]      = SPAWN_X + x_t'(lfsr[6:0]);
          type_n[i]   = lfsr[7];
          active_n[i] = 1'b1;
          spawned     = 1'b1;
        end
      end

      sum      = {1'b0, dodged_count} + {15'd0, expired};
      dodged_n = sum[16] ? 16'hFFFF : sum[15:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      x_q          <= '0;
      bean_type    <= '0;
      bean_active  <= '0;
      frozen       <= 1'b0;
      dodged_count <= '0;
    end else begin
      state        <= state_n;
      x_q          <= x_n;
      bean_type    <= type_n;
      bean_active  <= active_n;
      frozen       <= (state_n == HIT);
      dodged_count <= dodged_n;
    end
  end

  assign bean_x = x_q;

endmodule

// File: tb/tb_bean_scheduler.sv
// Directed bench for bean_scheduler; spawn positions are steered by waiting
// for chosen LFSR values from an independent LFSR model.
module tb_bean_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        tick = 1'b0;
  logic        start = 1'b0;
  logic        hit = 1'b0;
  logic        restart = 1'b0;
  logic [29:0] bean_x;
  logic [2:0]  bean_type;
  logic [2:0]  bean_active;
  logic        frozen;
  logic [15:0] dodged_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [15:0] m_lfsr;

  bean_scheduler dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .tick         (tick),
    .start        (start),
    .hit          (hit),
    .restart      (restart),
    .bean_x       (bean_x),
    .bean_type    (bean_type),
    .bean_active  (bean_active),
    .frozen       (frozen),
    .dodged_count (dodged_count)
  );

  always #5 clk = ~clk;

  // Reference LFSR: x^16+x^14+x^13+x^11+1, shift left, feedback into bit 0.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_lfsr <= 16'hACE1;
    else          m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  function automatic logic [9:0] slot_x(input int i);
    return bean_x[i*10 +: 10];
  endfunction

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic begin_run();
    restart = 1'b1; @(negedge clk); restart = 1'b0;
    pulse_start();
  endtask

  // Optionally waits until lfsr[6:0]==want_r so a spawn lands at 640+want_r.
  task automatic do_tick(input int want_r, output logic [15:0] used);
    int waited;
    waited = 0;
    if (want_r >= 0) begin
      while ((m_lfsr[6:0] != 7'(want_r)) && (waited < 8000)) begin
        @(negedge clk);
        waited++;
      end
      if (m_lfsr[6:0] != 7'(want_r)) begin
        total_cnt++;
        $display("FAIL lfsr_wait: got %0d required %0d", m_lfsr[6:0], want_r);
      end
    end
    used = m_lfsr;
    tick = 1'b1; @(negedge clk); tick = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    total_cnt++; if (bean_x !== 30'd0) $display("FAIL reset_x: got %h required 0", bean_x); else pass_cnt++;
    total_cnt++; if (bean_type !== 3'd0) $display("FAIL reset_type: got %b required 000", bean_type); else pass_cnt++;
    total_cnt++; if (bean_active !== 3'd0) $display("FAIL reset_active: got %b required 000", bean_active); else pass_cnt++;
    total_cnt++; if (frozen !== 1'b0) $display("FAIL reset_frozen: got %b required 0", frozen); else pass_cnt++;
    total_cnt++; if (dodged_count !== 16'd0) $display("FAIL reset_dodged: got %h required 0", dodged_count); else pass_cnt++;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_first_spawn();
    logic [15:0] used;
    do_tick(-1, used);
    total_cnt++; if (bean_active !== 3'b000) $display("FAIL idle_tick: got %b required 000", bean_active); else pass_cnt++;
    pulse_start();
    do_tick(-1, used);
    total_cnt++;
    if ({bean_active, bean_x} !== {3'b001, 20'd0, 10'd640 + {3'd0, used[6:0]}})
      $display("FAIL first_spawn: got %b/%h required 001 x0=%0d", bean_active, bean_x, 640 + used[6:0]);
    else pass_cnt++;
    total_cnt++; if (bean_type[0] !== used[7]) $display("FAIL first_type: got %b required %b", bean_type[0], used[7]); else pass_cnt++;
  endtask

  task automatic test_scroll_expire();
    logic [15:0] used;
    int want;
    begin_run();
    for (int n = 1; n <= 208; n++) begin
      case (n)
        1:        want = 60;
        54:       want = 126;
        120, 186: want = 127;
        default:  want = -1;
      endcase
      if (n == 208) begin
        force dut.dodged_count = 16'hFFFF;
        @(negedge clk);
        release dut.dodged_count;
      end
      do_tick(want, used);
      case (n)
        1: begin
          total_cnt++; if ({bean_active, bean_x} !== {3'b001, 20'd0, 10'd700}) $display("FAIL spawn_700: got %b/%h required 001 x0=700", bean_active, bean_x); else pass_cnt++;
        end
        2: begin
          total_cnt++; if (slot_x(0) !== 10'd695) $display("FAIL scroll_695: got %0d required 695", slot_x(0)); else pass_cnt++;
        end
        53: begin
          total_cnt++; if ({bean_active, bean_x} !== {3'b001, 20'd0, 10'd440}) $display("FAIL gap199_nospawn: got %b/%h required 001 x0=440", bean_active, bean_x); else pass_cnt++;
        end
        54: begin
          total_cnt++; if ({bean_active, slot_x(1), slot_x(0)} !== {3'b011, 10'd766, 10'd435}) $display("FAIL spawn_slot1: got %b/%h required 011 x1=766 x0=435", bean_active, bean_x); else pass_cnt++;
          total_cnt++; if (bean_type[1] !== used[7]) $display("FAIL slot1_type: got %b required %b", bean_type[1], used[7]); else pass_cnt++;
        end
        140: begin
          total_cnt++; if ({bean_active, slot_x(0)} !== {3'b111, 10'd5}) $display("FAIL slot_at_5: got %b/%0d required 111/5", bean_active, slot_x(0)); else pass_cnt++;
        end
        141: begin
          total_cnt++; if ({bean_active, bean_x} !== {3'b110, 10'd662, 10'd331, 10'd0}) $display("FAIL expire_5: got %b/%h required 110 662/331/0", bean_active, bean_x); else pass_cnt++;
          total_cnt++; if (dodged_count !== 16'd1) $display("FAIL dodged_1: got %0d required 1", dodged_count); else pass_cnt++;
        end
        186: begin
          total_cnt++; if ({bean_active, slot_x(0)} !== {3'b111, 10'd767}) $display("FAIL respawn_slot0: got %b/%0d required 111/767", bean_active, slot_x(0)); else pass_cnt++;
        end
        206: begin
          total_cnt++; if (slot_x(1) !== 10'd6) $display("FAIL slot_at_6: got %0d required 6", slot_x(1)); else pass_cnt++;
        end
        207: begin
          total_cnt++; if ({bean_active, slot_x(1)} !== {3'b111, 10'd1}) $display("FAIL six_to_1: got %b/%0d required 111/1", bean_active, slot_x(1)); else pass_cnt++;
        end
        208: begin
          total_cnt++; if ({bean_active, bean_x} !== {3'b101, 10'd327, 10'd0, 10'd657}) $display("FAIL expire_1: got %b/%h required 101 327/0/657", bean_active, bean_x); else pass_cnt++;
          total_cnt++; if (dodged_count !== 16'hFFFF) $display("FAIL dodged_sat: got %h required ffff", dodged_count); else pass_cnt++;
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_hit_restart();
    logic [15:0] used;
    hit = 1'b1; tick = 1'b1; @(negedge clk); hit = 1'b0; tick = 1'b0;
    total_cnt++; if ({frozen, bean_active, bean_x} !== {1'b1, 3'b101, 10'd327, 10'd0, 10'd657}) $display("FAIL hit_hold: got %b/%b/%h required 1/101 327/0/657", frozen, bean_active, bean_x); else pass_cnt++;
    repeat (3) do_tick(-1, used);
    total_cnt++; if ({frozen, bean_active, bean_x} !== {1'b1, 3'b101, 10'd327, 10'd0, 10'd657}) $display("FAIL frozen_ticks: got %b/%b/%h required 1/101 327/0/657", frozen, bean_active, bean_x); else pass_cnt++;
    restart = 1'b1; @(negedge clk); restart = 1'b0;
    total_cnt++; if ({frozen, bean_active, bean_x} !== 34'd0) $display("FAIL restart_clear: got %b/%b/%h required all 0", frozen, bean_active, bean_x); else pass_cnt++;
    total_cnt++; if (dodged_count !== 16'd0) $display("FAIL restart_dodged: got %h required 0", dodged_count); else pass_cnt++;
    do_tick(-1, used);
    total_cnt++; if (bean_active !== 3'b000) $display("FAIL restart_idle: got %b required 000", bean_active); else pass_cnt++;
  endtask

  task automatic test_gap();
    logic [15:0] used;
    int want;
    begin_run();
    for (int n = 1; n <= 124; n++) begin
      case (n)
        1:       want = 4;
        42, 83:  want = 0;
        default: want = -1;
      endcase
      do_tick(want, used);
      case (n)
        41: begin
          total_cnt++; if ({bean_active, bean_x} !== {3'b001, 20'd0, 10'd444}) $display("FAIL gap195_nospawn: got %b/%h required 001 x0=444", bean_active, bean_x); else pass_cnt++;
        end
        42: begin
          total_cnt++; if ({bean_active, bean_x} !== {3'b011, 10'd0, 10'd640, 10'd439}) $display("FAIL gap200_spawn: got %b/%h required 011 0/640/439", bean_active, bean_x); else pass_cnt++;
          total_cnt++; if (bean_type[1] !== used[7]) $display("FAIL gap_type: got %b required %b", bean_type[1], used[7]); else pass_cnt++;
        end
        83: begin
          total_cnt++; if ({bean_active, bean_x} !== {3'b111, 10'd640, 10'd435, 10'd234}) $display("FAIL spawn_slot2: got %b/%h required 111 640/435/234", bean_active, bean_x); else pass_cnt++;
        end
        124: begin
          total_cnt++; if ({bean_active, bean_x} !== {3'b111, 10'd435, 10'd230, 10'd29}) $display("FAIL full_nospawn: got %b/%h required 111 435/230/29", bean_active, bean_x); else pass_cnt++;
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_restart_priority();
    logic [15:0] used;
    begin_run();
    do_tick(-1, used);
    restart = 1'b1; hit = 1'b1; @(negedge clk); restart = 1'b0; hit = 1'b0;
    total_cnt++; if ({frozen, bean_active} !== 4'b0000) $display("FAIL restart_over_hit: got %b/%b required 0/000", frozen, bean_active); else pass_cnt++;
    do_tick(-1, used);
    total_cnt++; if ({frozen, bean_active} !== 4'b0000) $display("FAIL restart_to_idle: got %b/%b required 0/000", frozen, bean_active); else pass_cnt++;
    pulse_start();
    do_tick(-1, used);
    total_cnt++; if ({bean_active, slot_x(0)} !== {3'b001, 10'd640 + {3'd0, used[6:0]}}) $display("FAIL rerun_spawn: got %b/%0d required 001/%0d", bean_active, slot_x(0), 640 + used[6:0]); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    logic [15:0] used;
    begin_run();
    do_tick(60, used);
    repeat (40) do_tick(-1, used);
    total_cnt++; if ({bean_active, slot_x(0)} !== {3'b001, 10'd500}) $display("FAIL scroll_500: got %b/%0d required 001/500", bean_active, slot_x(0)); else pass_cnt++;
    hit = 1'b1; tick = 1'b1; @(negedge clk); hit = 1'b0; tick = 1'b0;
    total_cnt++; if ({frozen, slot_x(0)} !== {1'b1, 10'd500}) $display("FAIL hit_500: got %b/%0d required 1/500", frozen, slot_x(0)); else pass_cnt++;
    #2 reset_n = 1'b0;
    #1;
    total_cnt++; if ({frozen, bean_active, bean_x} !== 34'd0) $display("FAIL async_clear: got %b/%b/%h required all 0", frozen, bean_active, bean_x); else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    do_tick(-1, used);
    total_cnt++; if (bean_active !== 3'b000) $display("FAIL async_idle: got %b required 000", bean_active); else pass_cnt++;
    pulse_start();
    do_tick(-1, used);
    total_cnt++; if ({bean_active, bean_type[0], slot_x(0)} !== {3'b001, used[7], 10'd640 + {3'd0, used[6:0]}}) $display("FAIL async_respawn: got %b/%b/%0d required 001/%b/%0d", bean_active, bean_type[0], slot_x(0), used[7], 640 + used[6:0]); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_first_spawn();
    test_scroll_expire();
    test_hit_restart();
    test_gap();
    test_restart_priority();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
